// File: rtl/lbm_pkg.sv
// Shared LBM definitions: lattice lane indices and the chunk drain state encoding.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package lbm_pkg;

  // Nine D2Q9 lattice directions per pixel
  localparam int DIR_COUNT = 9;

  // Lane order inside a packed pixel, lane 0 in the least significant bits
  localparam int DIR_N    = 0;
  localparam int DIR_NULL = 1;
  localparam int DIR_NE   = 2;
  localparam int DIR_E    = 3;
  localparam int DIR_SE   = 4;
  localparam int DIR_S    = 5;
  localparam int DIR_SW   = 6;
  localparam int DIR_W    = 7;
  localparam int DIR_NW   = 8;

  typedef enum logic [1:0] {
    DRAIN_IDLE   = 2'd0,
    DRAIN_STREAM = 2'd1,
    DRAIN_FLUSH  = 2'd2,
    DRAIN_DONE   = 2'd3
  } drain_state_t;

endpackage

// File: rtl/lbm_chunk_drain_if.sv
// AXI-Stream beat bundle between the chunk drain (master) and the DDR write path (slave).
// Latency: none (wires only).
// Backpressure: tready from slave to master; master holds the beat until accepted.
interface lbm_chunk_drain_if
  import lbm_pkg::*;
#(
  parameter int TDATA_WIDTH = DIR_COUNT * 16
);
  logic                       tvalid;
  logic [TDATA_WIDTH-1:0]     tdata;
  logic [TDATA_WIDTH/8-1:0]   tstrb;
  logic                       tlast;
  logic                       tready;

  modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tstrb, input tlast, output tready);
endinterface

// File: rtl/axis_skid_fifo.sv
// Two-entry FIFO with the head held in a register, so rd_vld/rd_dat come straight from flops.
// Latency: a write becomes visible at the head one cycle later when the FIFO was empty.
// Backpressure: head is held while rd_rdy is low; the writer must not push into a full FIFO without a pop.
module axis_skid_fifo #(
  parameter int WIDTH = 145
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot0_q;
  logic [WIDTH-1:0] slot1_q;
  logic [1:0]       count_q;
  logic             pop;

  assign rd_vld = (count_q != 2'd0);
  assign rd_dat = slot0_q;
  assign count  = count_q;
  assign pop    = rd_vld && rd_rdy;

  // Slot update; slot1 is kept at zero whenever it is unused so an empty head reads as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      case ({wr_vld, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            slot0_q <= wr_dat;
            count_q <= 2'd1;
          end else if (count_q == 2'd1) begin
            slot1_q <= wr_dat;
            count_q <= 2'd2;
          end
        end
        2'b01: begin
          slot0_q <= slot1_q;
          slot1_q <= '0;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            slot0_q <= slot1_q;
            slot1_q <= wr_dat;
          end else begin
            slot0_q <= wr_dat;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/lbm_chunk_drain.sv
// Streams a finished chunk of DEPTH pixels from the BRAM bank out as one AXI-Stream packet.
// Latency: ren one cycle after chunk_result_ready is sampled, first beat two cycles later, then one beat per cycle.
// Backpressure: tready low holds the head beat; reads pause once buffered plus in-flight pixels reach two.
module lbm_chunk_drain
  import lbm_pkg::*;
#(
  parameter int DATA_WIDTH             = 16,
  parameter int DEPTH                  = 2500,
  parameter int ADDRESS_WIDTH          = 12,
  parameter int C_M00_AXIS_TDATA_WIDTH = 144
) (
  input  logic                              m00_axis_aclk,
  input  logic                              m00_axis_aresetn,
  input  logic                              chunk_result_ready,
  output logic                              chunk_drain_done,
  output logic                              ren,
  output logic [ADDRESS_WIDTH-1:0]          read_addr,
  input  logic [DIR_COUNT*DATA_WIDTH-1:0]   rd_data,
  lbm_chunk_drain_if.master                 m00_axis
);

  // One extra bit so a chunk of exactly 2^ADDRESS_WIDTH pixels can be counted to completion
  localparam int CW = ADDRESS_WIDTH + 1;
  localparam int FW = C_M00_AXIS_TDATA_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);

  drain_state_t    state_q;
  drain_state_t    state_d;
  logic [CW-1:0]   issue_cnt;
  logic [CW-1:0]   beat_cnt;
  logic            inflight;
  logic            inflight_last;
  logic [1:0]      buf_count;
  logic            buf_vld;
  logic [FW-1:0]   buf_dat;
  logic            beat_xfer;
  logic [2:0]      occ_now;

  assign beat_xfer = buf_vld && m00_axis.tready;
  assign occ_now   = {1'b0, buf_count} + {2'b00, inflight};
  assign read_addr = issue_cnt[ADDRESS_WIDTH-1:0];

  // Issue a read while pixels remain and the buffer will still have a free slot for it
  // once this cycle's pop and the read already in flight are accounted for
  always_comb begin
    ren = 1'b0;
    if ((state_q == DRAIN_STREAM) && (issue_cnt < DEPTH_C) &&
        (occ_now < (3'd2 + {2'b00, beat_xfer}))) begin
      ren = 1'b1;
    end
  end

  // Next-state logic and the completion pulse
  always_comb begin
    state_d          = state_q;
    chunk_drain_done = 1'b0;
    case (state_q)
      DRAIN_IDLE: begin
        if (chunk_result_ready) state_d = DRAIN_STREAM;
      end
      DRAIN_STREAM: begin
        if (issue_cnt == DEPTH_C) state_d = DRAIN_FLUSH;
      end
      DRAIN_FLUSH: begin
        if (beat_xfer && (beat_cnt == LAST_C)) state_d = DRAIN_DONE;
      end
      DRAIN_DONE: begin
        chunk_drain_done = 1'b1;
        // A still-asserted level means the solver already has the next chunk ready
        state_d = chunk_result_ready ? DRAIN_STREAM : DRAIN_IDLE;
      end
      default: state_d = DRAIN_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) state_q <= DRAIN_IDLE;
    else                   state_q <= state_d;
  end

  // Read/beat counters and the one-cycle BRAM latency tracker (tlast rides along with the data)
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      issue_cnt     <= '0;
      beat_cnt      <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= ren;
      inflight_last <= ren && (issue_cnt == LAST_C);
      if ((state_q == DRAIN_IDLE) || (state_q == DRAIN_DONE)) begin
        issue_cnt <= '0;
        beat_cnt  <= '0;
      end else begin
        if (ren)       issue_cnt <= issue_cnt + 1'b1;
        if (beat_xfer) beat_cnt  <= beat_cnt + 1'b1;
      end
    end
  end

  axis_skid_fifo #(
    .WIDTH (FW)
  ) u_skid (
    .clk    (m00_axis_aclk),
    .rst_n  (m00_axis_aresetn),
    .wr_vld (inflight),
    .wr_dat ({inflight_last, rd_data}),
    .rd_rdy (m00_axis.tready),
    .rd_vld (buf_vld),
    .rd_dat (buf_dat),
    .count  (buf_count)
  );

  assign m00_axis.tvalid = buf_vld;
  assign m00_axis.tdata  = buf_dat[C_M00_AXIS_TDATA_WIDTH-1:0];
  assign m00_axis.tlast  = buf_vld && buf_dat[FW-1];
  assign m00_axis.tstrb  = buf_vld ? '1 : '0;

endmodule

// File: tb/tb_lbm_chunk_drain.sv
// Bench for lbm_chunk_drain: a DEPTH=8 (ADDRESS_WIDTH=3) instance under random and patterned tready,
// plus a DEPTH=1 instance. Expected pixels come from a closed-form lane pattern per chunk.
// A negedge monitor scores every beat, read address, stall hold and completion pulse.
module tb_lbm_chunk_drain;
  import lbm_pkg::*;

  localparam int DW  = 16;
  localparam int TW  = 144;
  localparam int D8  = 8;
  localparam int AW8 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            crr, done, ren;
  logic [AW8-1:0]  raddr;
  logic [TW-1:0]   rdata;
  logic            crr1, done1, ren1;
  logic [0:0]      raddr1;
  logic [TW-1:0]   rdata1;
  logic [15:0]     cur_base, cur_base1;

  lbm_chunk_drain_if #(.TDATA_WIDTH(TW)) axis ();
  lbm_chunk_drain_if #(.TDATA_WIDTH(TW)) axis1 ();

  lbm_chunk_drain #(
    .DATA_WIDTH(DW), .DEPTH(D8), .ADDRESS_WIDTH(AW8), .C_M00_AXIS_TDATA_WIDTH(TW)
  ) u_dut (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .chunk_result_ready(crr),
    .chunk_drain_done(done), .ren(ren), .read_addr(raddr), .rd_data(rdata), .m00_axis(axis)
  );

  lbm_chunk_drain #(
    .DATA_WIDTH(DW), .DEPTH(1), .ADDRESS_WIDTH(1), .C_M00_AXIS_TDATA_WIDTH(TW)
  ) u_dut1 (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .chunk_result_ready(crr1),
    .chunk_drain_done(done1), .ren(ren1), .read_addr(raddr1), .rd_data(rdata1), .m00_axis(axis1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Pixel idx of a chunk: lane j holds base + idx*16 + j
  function automatic logic [TW-1:0] pixel(input logic [15:0] base, input int idx);
    logic [TW-1:0] p;
    p = '0;
    for (int j = 0; j < DIR_COUNT; j++)
      p[j*DW +: DW] = base + 16'(idx * 16) + 16'(j);
    return p;
  endfunction

  // BRAM models: address seen with ren in one cycle, data presented the next cycle
  initial begin : bram_model
    logic pend, pend1;
    logic [AW8-1:0] pa;
    logic [0:0] pa1;
    rdata = '0; rdata1 = '0;
    forever begin
      @(negedge clk);
      pend = ren;  pa  = raddr;
      pend1 = ren1; pa1 = raddr1;
      @(posedge clk); #1;
      if (pend)  rdata  = pixel(cur_base, int'(pa));
      if (pend1) rdata1 = pixel(cur_base1, int'(pa1));
    end
  end

  // Scoreboard state for the DEPTH=8 instance
  int            issued = 0;
  int            mon_beat = 0;
  logic          expect_done = 1'b0;
  logic          stall_prev = 1'b0;
  logic          prev_last = 1'b0;
  logic [TW-1:0] prev_dat = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      issued = 0; mon_beat = 0; expect_done = 1'b0; stall_prev = 1'b0;
    end else begin
      chk("tstrb", TW'(axis.tstrb), axis.tvalid ? TW'(18'h3FFFF) : TW'(0));
      chk("done_pulse", TW'(done), TW'(expect_done));
      if (expect_done) begin
        expect_done = 1'b0; issued = 0; mon_beat = 0;
      end
      if (stall_prev) begin
        chk("hold_vld", TW'(axis.tvalid), TW'(1));
        chk("hold_dat", axis.tdata, prev_dat);
        chk("hold_last", TW'(axis.tlast), TW'(prev_last));
      end
      if (ren) begin
        chk("ren_addr", TW'(raddr), TW'(issued % D8));
        chk("ren_in_range", TW'(issued < D8), TW'(1));
        issued++;
      end
      if (axis.tvalid && axis.tready) begin
        chk("beat_dat", axis.tdata, pixel(cur_base, mon_beat));
        chk("beat_last", TW'(axis.tlast), TW'(mon_beat == D8 - 1));
        if (mon_beat == D8 - 1) expect_done = 1'b1;
        mon_beat++;
      end
      chk("outstanding", TW'((issued - mon_beat) <= 2), TW'(1));
      stall_prev = axis.tvalid && !axis.tready;
      prev_dat   = axis.tdata;
      prev_last  = axis.tlast;
    end
  end

  // One packet on the DEPTH=8 instance; mode 0: tready=1, 1: 1,0,0,1 pattern, else random
  task automatic run_packet(input int mode, input logic [15:0] base);
    bit seen;
    seen = 1'b0;
    cur_base = base;
    crr = 1'b1;
    for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
      @(posedge clk); #1;
      crr = 1'b0;
      case (mode)
        0:       axis.tready = 1'b1;
        1:       axis.tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: axis.tready = 1'($urandom_range(0, 1));
      endcase
      if (done) seen = 1'b1;
    end
    chk("pkt_done_seen", TW'(seen), TW'(1));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ren"},   TW'(ren), TW'(0));
    chk({tag, "_addr"},  TW'(raddr), TW'(0));
    chk({tag, "_vld"},   TW'(axis.tvalid), TW'(0));
    chk({tag, "_dat"},   axis.tdata, TW'(0));
    chk({tag, "_strb"},  TW'(axis.tstrb), TW'(0));
    chk({tag, "_last"},  TW'(axis.tlast), TW'(0));
    chk({tag, "_done"},  TW'(done), TW'(0));
  endtask

  initial begin
    bit seen;
    rst_n = 1'b1; crr = 1'b0; crr1 = 1'b0;
    axis.tready = 1'b0; axis1.tready = 1'b0;
    cur_base = '0; cur_base1 = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Cycle-exact timing with tready held high and the base-0 pattern
    cur_base = 16'h0; axis.tready = 1'b1; crr = 1'b1;
    @(posedge clk); #1; crr = 1'b0;
    chk("t_ren_k1", TW'(ren), TW'(1));
    chk("t_addr_k1", TW'(raddr), TW'(0));
    @(posedge clk); #1;
    chk("t_vld_k2", TW'(axis.tvalid), TW'(0));
    @(posedge clk); #1;
    chk("t_vld_k3", TW'(axis.tvalid), TW'(1));
    chk("t_dat_k3", axis.tdata, pixel(16'h0, 0));
    chk("t_last_k3", TW'(axis.tlast), TW'(0));
    repeat (D8 - 1) @(posedge clk); #1;
    chk("t_last_final", TW'(axis.tlast), TW'(1));
    @(posedge clk); #1;
    chk("t_done", TW'(done), TW'(1));
    @(posedge clk); #1;
    chk("t_done_once", TW'(done), TW'(0));
    chk("t_idle_ren", TW'(ren), TW'(0));

    // Patterned and random backpressure
    run_packet(1, 16'($urandom));
    for (int p = 0; p < 3; p++) begin
      @(posedge clk); #1;
      run_packet(2, 16'($urandom));
    end
    @(posedge clk); #1;

    // Long stall right after the first beat appears
    axis.tready = 1'b0; cur_base = 16'($urandom); crr = 1'b1;
    @(posedge clk); #1; crr = 1'b0;
    for (int i = 0; i < 10 && !axis.tvalid; i++) begin
      @(posedge clk); #1;
    end
    chk("stall_first_vld", TW'(axis.tvalid), TW'(1));
    repeat (20) @(posedge clk); #1;
    chk("stall_reads", TW'(issued), TW'(2));
    chk("stall_head", axis.tdata, pixel(cur_base, 0));
    axis.tready = 1'b1;
    repeat (D8) @(posedge clk); #1;
    chk("stall_resume_done", TW'(done), TW'(1));
    @(posedge clk); #1;

    // Level held across DONE: next packet starts immediately
    cur_base = 16'($urandom); axis.tready = 1'b1; crr = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("b2b_first_done", TW'(seen), TW'(1));
    @(posedge clk); #1;
    chk("b2b_ren", TW'(ren), TW'(1));
    chk("b2b_addr", TW'(raddr), TW'(0));
    crr = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("b2b_second_done", TW'(seen), TW'(1));
    @(posedge clk); #1;

    // Pulse mid-stream must not start another packet
    cur_base = 16'($urandom); crr = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk); #1;
      crr = (i == 4);
      axis.tready = 1'($urandom_range(0, 1));
      if (done) seen = 1'b1;
    end
    chk("pulse_done", TW'(seen), TW'(1));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("pulse_ignored_ren", TW'(ren), TW'(0));
      chk("pulse_ignored_vld", TW'(axis.tvalid), TW'(0));
    end

    // Reset while beat 3 is on the bus, then a clean restart
    cur_base = 16'($urandom); axis.tready = 1'b1; crr = 1'b1;
    @(posedge clk); #1; crr = 1'b0;
    for (int i = 0; i < 20 && mon_beat != 3; i++) begin
      @(posedge clk); #1;
    end
    chk("rst_at_beat3", TW'(mon_beat), TW'(3));
    rst_n = 1'b0; #1;
    chk_outputs_zero("midrst");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_packet(2, 16'($urandom));
    @(posedge clk); #1;

    // Single-pixel chunk
    cur_base1 = 16'($urandom); axis1.tready = 1'b1; crr1 = 1'b1;
    @(posedge clk); #1; crr1 = 1'b0;
    chk("d1_ren", TW'(ren1), TW'(1));
    chk("d1_addr", TW'(raddr1), TW'(0));
    @(posedge clk); #1;
    chk("d1_vld_k2", TW'(axis1.tvalid), TW'(0));
    @(posedge clk); #1;
    chk("d1_vld", TW'(axis1.tvalid), TW'(1));
    chk("d1_last", TW'(axis1.tlast), TW'(1));
    chk("d1_strb", TW'(axis1.tstrb), TW'(18'h3FFFF));
    chk("d1_dat", axis1.tdata, pixel(cur_base1, 0));
    @(posedge clk); #1;
    chk("d1_done", TW'(done1), TW'(1));
    chk("d1_vld_after", TW'(axis1.tvalid), TW'(0));
    @(posedge clk); #1;
    chk("d1_done_once", TW'(done1), TW'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
